// File: rtl/tc1_sensor_emulator.sv
// MAX31855 thermocouple converter model for the Pmod TC1 SPI pins, oversampled in s_axi_aclk.
// Optional build macro TC1_EMU_FAULT_INJECT_EN adds a fault_inject input ORed into each frame.
`timescale 1ns/1ps
module tc1_sensor_emulator #(
   parameter int                 SYNC_STAGES = 2,
   parameter int                 FRAME_CNT_W = 16,
   parameter logic [13:0]        INIT_JUNC_T = 14'h0190,
   parameter logic [11:0]        INIT_INT_T  = 12'h190
) (
   input  logic                   s_axi_aclk,
   input  logic                   s_axi_aresetn,
   input  logic                   SCLK,
   input  logic                   CSn,
   output logic                   MISO,
   input  logic [13:0]            junc_t_in,
   input  logic [11:0]            internal_t_in,
   input  logic [2:0]             faults_in,
`ifdef TC1_EMU_FAULT_INJECT_EN
   input  logic [2:0]             fault_inject,
`endif
   input  logic                   load_valid,
   output logic                   load_ready,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   partial_done,
   output logic [FRAME_CNT_W-1:0] frame_count
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                 state, state_next;
   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
   logic                   sclk_d, cs_d;
   logic                   sclk_s, cs_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [13:0]            val_junc;
   logic [11:0]            val_int;
   logic [2:0]             val_faults;
   logic [2:0]             frame_faults;
   logic [31:0]            frame_word;
   logic [31:0]            shift_q;
   logic [4:0]             bit_cnt;
   logic [5:0]             rise_cnt;
   logic                   load_shift, do_shift, count_rise, end_frame, full_frame;

   // Pin synchronizers reset to the idle bus levels so reset release never looks like an edge.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a real chain.
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CSn};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;

`ifdef TC1_EMU_FAULT_INJECT_EN
   assign frame_faults = val_faults | fault_inject;
`else
   assign frame_faults = val_faults;
`endif
   assign frame_word = {val_junc, 1'b0, |frame_faults, val_int, 1'b0, frame_faults};

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) state <= IDLE;
      else                state <= state_next;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
      state_next = state;
      load_shift = 1'b0;
      do_shift   = 1'b0;
      count_rise = 1'b0;
      end_frame  = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               load_shift = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            // Chip-select release takes priority over a coincident SCLK fall.
            if (cs_rise) begin
               end_frame  = 1'b1;
               state_next = IDLE;
            end else begin
               count_rise = sclk_rise && (rise_cnt < 6'd32);
               if (sclk_fall) begin
                  if (bit_cnt == 5'd31) state_next = DONE;
                  else                  do_shift   = 1'b1;
               end
            end
         end
         DONE: begin
            if (cs_rise) begin
               end_frame  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign full_frame = rise_cnt >= 6'd32;

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         // NOTE: the value register resets to the INIT frame so a read right after reset is defined.
         val_junc     <= INIT_JUNC_T;
         val_int      <= INIT_INT_T;
         val_faults   <= 3'b000;
         shift_q      <= '0;
         bit_cnt      <= '0;
         rise_cnt     <= '0;
         frame_done   <= 1'b0;
         partial_done <= 1'b0;
         frame_count  <= '0;
      end else begin
         frame_done   <= end_frame & full_frame;
         partial_done <= end_frame & ~full_frame;
         if (end_frame && full_frame) frame_count <= frame_count + FRAME_CNT_W'(1);

         // A load coincident with cs_fall lands here while the shift register takes the old frame.
         if (load_valid && load_ready) begin
            val_junc   <= junc_t_in;
            val_int    <= internal_t_in;
            val_faults <= faults_in;
         end

         if (load_shift) begin
            shift_q  <= frame_word;
            bit_cnt  <= '0;
            rise_cnt <= '0;
         end else begin
            if (do_shift) begin
               shift_q <= {shift_q[30:0], 1'b0};
               bit_cnt <= bit_cnt + 5'd1;
            end
            if (count_rise) rise_cnt <= rise_cnt + 6'd1;
         end
      end
   end

   assign MISO       = (state == SHIFT) ? shift_q[31] : 1'b0;
   assign load_ready = (state == IDLE);
   assign busy       = ~cs_s;

endmodule

// File: tb/tb_tc1_sensor_emulator.sv
// Bench for tc1_sensor_emulator: SPI master drives reads, a scoreboard checks each frame-end pulse.
`timescale 1ns/1ps
module tb_tc1_sensor_emulator;

   logic        clk, rst_n;
   logic        sclk, cs_n, miso;
   logic [13:0] junc_t;
   logic [11:0] int_t;
   logic [2:0]  faults;
   logic [2:0]  fault_inject;
   logic        load_valid, load_ready, busy, frame_done, partial_done;
   logic [15:0] frame_count;

   typedef struct {
      bit          full;
      logic [31:0] data;
      int          count;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] last_cap;
   int          exp_count;
   int          n_vec;
   int          n_err;

   tc1_sensor_emulator dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .SCLK          (sclk),
      .CSn           (cs_n),
      .MISO          (miso),
      .junc_t_in     (junc_t),
      .internal_t_in (int_t),
      .faults_in     (faults),
`ifdef TC1_EMU_FAULT_INJECT_EN
      .fault_inject  (fault_inject),
`endif
      .load_valid    (load_valid),
      .load_ready    (load_ready),
      .busy          (busy),
      .frame_done    (frame_done),
      .partial_done  (partial_done),
      .frame_count   (frame_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every frame-end pulse consumes one expected entry.
   always @(negedge clk) begin
      if (frame_done || partial_done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("frame_done_kind", {31'd0, frame_done}, {31'd0, mon_e.full});
            check("captured_word", last_cap, mon_e.data);
            check("frame_count", {16'd0, frame_count}, mon_e.count);
         end
      end
   end

   // SPI mode-0 master at 5 MHz: sample MISO then raise SCLK; slave shifts on the falling edge.
   task automatic spi_read(input int nbits, input logic [31:0] exp_cap, input int load_at);
      exp_t        e;
      logic [31:0] cap;
      e.full = (nbits >= 32);
      if (e.full) exp_count++;
      e.data  = exp_cap;
      e.count = exp_count;
      exp_q.push_back(e);
      @(negedge clk);
      cap  = '0;
      cs_n = 1'b0;
      #100;
      for (int i = 0; i < nbits; i++) begin
         if (i == 1) check("busy_in_frame", {31'd0, busy}, 32'd1);
         if (load_at >= 0 && i == load_at) begin
            junc_t     = 14'h0064;
            int_t      = 12'h190;
            faults     = 3'b000;
            load_valid = 1'b1;
         end
         if (load_at >= 0 && i == load_at + 2)
            check("load_ready_mid_frame", {31'd0, load_ready}, 32'd0);
         cap  = {cap[30:0], miso};
         sclk = 1'b1;
         #100;
         sclk = 1'b0;
         #100;
      end
      last_cap = cap;
      cs_n     = 1'b1;
      #300;
   endtask

   task automatic do_load(input logic [13:0] j, input logic [11:0] it, input logic [2:0] f);
      @(negedge clk);
      junc_t     = j;
      int_t      = it;
      faults     = f;
      load_valid = 1'b1;
      check("load_ready_idle", {31'd0, load_ready}, 32'd1);
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   initial begin
      n_vec        = 0;
      n_err        = 0;
      exp_count    = 0;
      last_cap     = '0;
      rst_n        = 1'b0;
      sclk         = 1'b0;
      cs_n         = 1'b1;
      junc_t       = '0;
      int_t        = '0;
      faults       = '0;
      fault_inject = '0;
      load_valid   = 1'b0;

      #23;
      check("reset_miso", {31'd0, miso}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_load_ready", {31'd0, load_ready}, 32'd1);
      check("reset_frame_done", {31'd0, frame_done}, 32'd0);
      check("reset_partial_done", {31'd0, partial_done}, 32'd0);
      check("reset_frame_count", {16'd0, frame_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // INIT frame: junc 0x0190 at [31:18], internal 0x190 at [15:4].
      spi_read(32, 32'h0640_1900, -1);

      // Negative junction, negative internal, OC fault.
      do_load(14'h3FFC, 12'hFF0, 3'b001);
      spi_read(32, 32'hFFF1_FF01, -1);

      // Early termination after 16 bits returns the upper half, then a full read restarts at bit 31.
      spi_read(16, 32'h0000_FFF1, -1);
      spi_read(32, 32'hFFF1_FF01, -1);

      // Load held from mid-frame: this frame unchanged, the next carries junc 0x0064.
      spi_read(32, 32'hFFF1_FF01, 10);
      @(negedge clk);
      load_valid = 1'b0;
      spi_read(32, 32'h0190_1900, -1);

      // Reset mid-frame while MISO shows bit 23 (a 1) of 0x0190_1900.
      @(negedge clk);
      cs_n = 1'b0;
      #100;
      repeat (8) begin
         sclk = 1'b1;
         #100;
         sclk = 1'b0;
         #100;
      end
      check("miso_before_reset", {31'd0, miso}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("miso_async_reset", {31'd0, miso}, 32'd0);
      check("busy_async_reset", {31'd0, busy}, 32'd0);
      check("count_async_reset", {16'd0, frame_count}, 32'd0);
      cs_n = 1'b1;
      exp_count = 0;
      #50;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      spi_read(32, 32'h0640_1900, -1);

`ifdef TC1_EMU_FAULT_INJECT_EN
      fault_inject = 3'b100;
      spi_read(32, 32'h0641_1904, -1);
      fault_inject = 3'b000;
      spi_read(32, 32'h0640_1900, -1);
`endif

      #1000;
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
